pkt_fifo_sf: RTL and testbench
==============================

Name: pkt_fifo_sf

Overview:
Parametrised store-and-forward AXI-Stream packet FIFO, successor to the single-width packet queue. Whole packets are written to an internal dual-port RAM; a packet becomes visible to the read side only after its tlast beat is committed. Overflowing or explicitly aborted packets are rolled back atomically, so the egress never sees partial packets. Sits between a MAC/parser ingress and downstream packet processing, one instance per stream.

Parameters:
C_DATA_WIDTH, 256, tdata width in bits
C_MTY_WIDTH, 5, tuser_mty width (empty-byte count on the last beat)
C_MAX_DEPTH_BITS, 9, log2 of RAM entries; capacity 2**C_MAX_DEPTH_BITS beats
C_PKT_CNT_BITS, 8, width of the committed-packet counter; limits stored packets to 2**C_PKT_CNT_BITS-1

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
s_axis_tvalid  in  1  ingress beat valid
s_axis_tdata  in  C_DATA_WIDTH  ingress data
s_axis_tlast  in  1  ingress end of packet
s_axis_tuser_mty  in  C_MTY_WIDTH  ingress empty bytes
s_axis_tready  out  1  ingress ready
drop_incmpt_pkt  in  1  abort the packet currently being written
m_axis_tvalid  out  1  egress valid
m_axis_tdata  out  C_DATA_WIDTH  egress data
m_axis_tlast  out  1  egress end of packet
m_axis_tuser_mty  out  C_MTY_WIDTH  egress empty bytes
m_axis_tready  in  1  egress ready
fill_level  out  C_MAX_DEPTH_BITS+1  committed beats in RAM plus output stage, registered
pkt_count  out  C_PKT_CNT_BITS  committed packets not yet fully read, registered
drop_pulse  out  1  one-cycle pulse per discarded packet
drop_cnt  out  32  saturating count of discarded packets

Behaviour:
- Reset (async assert, sync deassert expected upstream): all pointers, counters, and output stage are cleared; s_axis_tready=0 during reset and 1 from the first clock after; m_axis_tvalid=0, m_axis_tdata/tlast/tuser_mty=0, fill_level=0, pkt_count=0, drop_pulse=0, drop_cnt=0. Reset mid-packet loses everything, with no drop counted.
- Pointers: wr_p, wr_commit, and rd_p are C_MAX_DEPTH_BITS+1 wide, with an extra wrap bit. Full when wr_p - rd_p == 2**C_MAX_DEPTH_BITS. All pointer arithmetic is modulo 2**(C_MAX_DEPTH_BITS+1).
- Ingress policy is accept-and-drop: s_axis_tready stays 1 outside reset. A beat is accepted when tvalid&tready.
- Write FSM states: IDLE, WRITE, DISCARD.
  - IDLE -> WRITE on the first accepted beat.
  - In WRITE, beats are written at wr_p, then wr_p++.
  - An accepted beat with tlast: wr_commit <= wr_p+1 and pkt_count++ on the next edge; the FSM returns to IDLE. A single-beat packet does the same from IDLE.
  - Overflow: an accepted beat arriving while full, or while pkt_count is at max, triggers wr_p <= wr_commit, drop_pulse, and drop_cnt++. The FSM goes to DISCARD, or to IDLE if that beat had tlast.
  - DISCARD: all beats are dropped through tlast, then IDLE.
  - drop_incmpt_pkt=1 while in WRITE, or with an accepted beat: immediate rollback plus a drop. It beats a simultaneous tlast, so that packet is discarded. Following beats of the same packet go to DISCARD unless the beat had tlast. drop_incmpt_pkt in IDLE with no beat has no effect.
  - Packets longer than capacity are always discarded.
- Read side: reads only addresses in [rd_p, wr_commit). The RAM has 1-cycle read latency. The output stage is a 2-entry skid buffer.
  - A read is issued when committed data is available and (occupancy + in-flight) < 2.
  - This sustains 1 beat/cycle with m_axis_tready held high.
  - m_axis_* is driven from the skid head. tdata/tlast/mty stay stable while tvalid=1 and tready=0.
- Latency: a tlast beat accepted at edge T into an empty FIFO gives m_axis_tvalid=1 at edge T+3. Earlier beats of that packet are not presented before then.
- pkt_count-- on egress tlast handshake. If that coincides with a commit, the count is unchanged.
- Simultaneous write rollback and read are legal. The read side never crosses wr_commit.
- drop_cnt saturates at 32'hFFFFFFFF.
- fill_level = wr_commit - rd_p + skid occupancy + in-flight read. It excludes the uncommitted partial packet.

Decomposition:
- Shared package pkt_fifo_pkg: write FSM state enum (IDLE/WRITE/DISCARD); the beat record width constant C_DATA_WIDTH+1+C_MTY_WIDTH; and the {data,last,mty} packing order, which is data in the MSBs, then last, then mty.
- One sub-module: sdp_ram, a simple dual-port RAM with parameters width and depth_bits, registered read, one clock, and no reset on the array.

Test Plan:
1. Reset, then 3 packets of 4/1/7 beats, tready=1 -> egress is identical, in order, back-to-back at 1 beat/cycle. The first tvalid comes 3 cycles after the first tlast is accepted. pkt_count peaks at 3 and ends at 0.
2. C_MAX_DEPTH_BITS=4 (16 beats); send a 20-beat packet, then a 3-beat packet -> the first is dropped (drop_pulse once, drop_cnt=1, nothing egresses), the 3-beat packet egresses intact, and fill_level never exceeds 16.
3. 5-beat packet, with drop_incmpt_pkt asserted together with beat 3, remaining beats sent -> no egress, drop_cnt=1, wr_p restored. A following 2-beat packet passes intact.
4. drop_incmpt_pkt coincident with the tlast beat of a 4-beat packet -> packet discarded, pkt_count stays 0, no m_axis_tvalid.
5. Fill with 2 packets, then toggle m_axis_tready randomly at 50% -> data is stable while stalled, with no duplicated or lost beats. Meanwhile ingress writes a third packet that commits during reads, and pkt_count stays correct.
6. Assert areset asynchronously mid-egress and mid-ingress -> outputs zero immediately, pkt_count=0 and fill_level=0. After release, a 2-beat packet passes normally.

Source files
------------

// File: rtl/pkt_fifo_sf_pkg.sv
// Shared types for the store-and-forward packet FIFO.
// Beats are packed {data, last, mty}: data in the MSBs, then last, then mty in the LSBs.
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    localparam int C_DATA_WIDTH_DFLT = 256;
    localparam int C_MTY_WIDTH_DFLT  = 5;
    localparam int C_BEAT_WIDTH_DFLT = C_DATA_WIDTH_DFLT + 1 + C_MTY_WIDTH_DFLT;

    function automatic int beat_width(input int data_w, input int mty_w);
        return data_w + 1 + mty_w;
    endfunction

endpackage

// File: rtl/pkt_fifo_sf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// The array has no reset.
module sdp_ram #(
    parameter int width      = 8,
    parameter int depth_bits = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [depth_bits-1:0] wr_addr,
    input  logic [width-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [depth_bits-1:0] rd_addr,
    output logic [width-1:0]      rd_data
);

    logic [width-1:0] mem [2**depth_bits];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward AXI-Stream packet FIFO: packets become readable only once their
// tlast beat commits; overflowing or aborted packets are rolled back whole.
//
//   state   | meaning
//   IDLE    | between packets, waiting for a first beat
//   WRITE   | storing beats of the current packet
//   DISCARD | dropping the rest of a rolled-back packet through tlast
module pkt_fifo_sf
    import pkt_fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH     = 256,
    parameter int C_MTY_WIDTH      = 5,
    parameter int C_MAX_DEPTH_BITS = 9,
    parameter int C_PKT_CNT_BITS   = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        s_axis_tvalid,
    input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic [C_MTY_WIDTH-1:0]      s_axis_tuser_mty,
    output logic                        s_axis_tready,
    input  logic                        drop_incmpt_pkt,
    output logic                        m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]      m_axis_tuser_mty,
    input  logic                        m_axis_tready,
    output logic [C_MAX_DEPTH_BITS:0]   fill_level,
    output logic [C_PKT_CNT_BITS-1:0]   pkt_count,
    output logic                        drop_pulse,
    output logic [31:0]                 drop_cnt
);

    localparam int C_BEAT_W = beat_width(C_DATA_WIDTH, C_MTY_WIDTH);
    localparam int C_PTR_W  = C_MAX_DEPTH_BITS + 1;

    typedef logic [C_PTR_W-1:0] ptr_t;

    localparam ptr_t C_CAPACITY = ptr_t'(2**C_MAX_DEPTH_BITS);
    localparam ptr_t C_PTR_ONE  = ptr_t'(1);
    localparam logic [C_PKT_CNT_BITS-1:0] C_PKT_MAX = '1;
    localparam logic [C_PKT_CNT_BITS-1:0] C_PKT_ONE = C_PKT_CNT_BITS'(1);

    wr_state_t state, state_nxt;

    ptr_t wr_p, wr_commit, commit_vis, rd_p;
    logic accept, full, pkt_at_max;
    logic do_write, do_commit, do_drop;

    logic [C_BEAT_W-1:0] ram_rdata, skid0, skid1;
    logic [1:0]          occ, slots;
    logic                inflight, issue, avail, pop;

    assign accept     = s_axis_tvalid & s_axis_tready;
    assign full       = (wr_p - rd_p) == C_CAPACITY;
    assign pkt_at_max = pkt_count == C_PKT_MAX;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_drop   = 1'b0;
        case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    if (drop_incmpt_pkt || full || pkt_at_max) begin
                        do_drop   = 1'b1;
                        state_nxt = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        do_write = 1'b1;
                        if (s_axis_tlast) begin
                            do_commit = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = WRITE;
                        end
                    end
                end else if (state == WRITE && drop_incmpt_pkt) begin
                    do_drop   = 1'b1;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (accept && s_axis_tlast)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // commit_vis delays commits to the read side by one cycle, fixing ingress-to-egress latency
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s_axis_tready <= 1'b0;
            wr_p          <= '0;
            wr_commit     <= '0;
            commit_vis    <= '0;
            drop_pulse    <= 1'b0;
            drop_cnt      <= '0;
            pkt_count     <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            commit_vis    <= wr_commit;
            drop_pulse    <= do_drop;
            if (do_drop) begin
                wr_p <= wr_commit;
                if (drop_cnt != 32'hFFFF_FFFF)
                    drop_cnt <= drop_cnt + 32'd1;
            end else if (do_write) begin
                wr_p <= wr_p + C_PTR_ONE;
                if (do_commit)
                    wr_commit <= wr_p + C_PTR_ONE;
            end
            case ({do_commit, pop & m_axis_tlast})
                2'b10:   pkt_count <= pkt_count + C_PKT_ONE;
                2'b01:   pkt_count <= pkt_count - C_PKT_ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    sdp_ram #(
        .width      (C_BEAT_W),
        .depth_bits (C_MAX_DEPTH_BITS)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (do_write),
        .wr_addr (wr_p[C_MAX_DEPTH_BITS-1:0]),
        .wr_data ({s_axis_tdata, s_axis_tlast, s_axis_tuser_mty}),
        .rd_en   (issue),
        .rd_addr (rd_p[C_MAX_DEPTH_BITS-1:0]),
        .rd_data (ram_rdata)
    );

    // slots is the skid occupancy after this cycle's pop and landing read
    assign m_axis_tvalid = occ != 2'd0;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign avail         = rd_p != commit_vis;
    assign slots         = occ - {1'b0, pop} + {1'b0, inflight};
    assign issue         = avail && (slots < 2'd2);

    assign m_axis_tdata     = skid0[C_BEAT_W-1 -: C_DATA_WIDTH];
    assign m_axis_tlast     = skid0[C_MTY_WIDTH];
    assign m_axis_tuser_mty = skid0[C_MTY_WIDTH-1:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_p       <= '0;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            skid0      <= '0;
            skid1      <= '0;
            fill_level <= '0;
        end else begin
            inflight <= issue;
            occ      <= slots;
            if (issue)
                rd_p <= rd_p + C_PTR_ONE;
            if (inflight) begin
                if (pop) begin
                    if (occ == 2'd2) begin
                        skid0 <= skid1;
                        skid1 <= ram_rdata;
                    end else begin
                        skid0 <= ram_rdata;
                    end
                end else if (occ == 2'd0) begin
                    skid0 <= ram_rdata;
                end else begin
                    skid1 <= ram_rdata;
                end
            end else if (pop) begin
                skid0 <= skid1;
            end
            fill_level <= (wr_commit - rd_p) + ptr_t'(occ) + ptr_t'(inflight);
        end
    end

endmodule

// File: tb/tb_pkt_fifo_sf.sv
// Directed bench for pkt_fifo_sf, built with a 16-beat RAM and 32-bit data.
module tb_pkt_fifo_sf;

    typedef logic [34:0] beat_t;

    logic        aclk;
    logic        areset;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic [1:0]  s_axis_tuser_mty;
    logic        s_axis_tready;
    logic        drop_incmpt_pkt;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [1:0]  m_axis_tuser_mty;
    logic        m_axis_tready;
    logic [4:0]  fill_level;
    logic [7:0]  pkt_count;
    logic        drop_pulse;
    logic [31:0] drop_cnt;

    int n_err, n_checks;
    beat_t got_q[$], exp_q[$];
    int hs_cyc[$];
    int cyc, n_valid, n_drop_pulse, n_tlast, n_unstable, max_fill, max_pkt;
    bit stall_prev;
    beat_t prev_beat;

    pkt_fifo_sf #(
        .C_DATA_WIDTH     (32),
        .C_MTY_WIDTH      (2),
        .C_MAX_DEPTH_BITS (4),
        .C_PKT_CNT_BITS   (8)
    ) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser_mty (s_axis_tuser_mty),
        .s_axis_tready    (s_axis_tready),
        .drop_incmpt_pkt  (drop_incmpt_pkt),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser_mty (m_axis_tuser_mty),
        .m_axis_tready    (m_axis_tready),
        .fill_level       (fill_level),
        .pkt_count        (pkt_count),
        .drop_pulse       (drop_pulse),
        .drop_cnt         (drop_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        beat_t cur;
        cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser_mty};
        if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(cur);
            hs_cyc.push_back(cyc);
            if (m_axis_tlast) n_tlast++;
        end
        if (m_axis_tvalid) n_valid++;
        if (drop_pulse) n_drop_pulse++;
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        if (int'(pkt_count) > max_pkt) max_pkt = int'(pkt_count);
        if (stall_prev && (!m_axis_tvalid || cur !== prev_beat)) n_unstable++;
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat  = cur;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic beat_t mk_beat(input int id, input int i, input int len);
        logic [31:0] d;
        logic        l;
        logic [1:0]  m;
        d = {id[15:0], i[15:0]};
        l = (i == len - 1);
        m = l ? id[1:0] : 2'b00;
        return {d, l, m};
    endfunction

    task automatic drive_beat(input beat_t b, input bit drop);
        s_axis_tvalid    = 1'b1;
        s_axis_tdata     = b[34:3];
        s_axis_tlast     = b[2];
        s_axis_tuser_mty = b[1:0];
        drop_incmpt_pkt  = drop;
    endtask

    task automatic idle_in();
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        drop_incmpt_pkt = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int len, input int drop_at,
                            input bit rnd_rdy, input bit expect_pass);
        for (int i = 0; i < len; i++) begin
            drive_beat(mk_beat(id, i, len), (i + 1) == drop_at);
            if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
            if (expect_pass) exp_q.push_back(mk_beat(id, i, len));
            tick();
        end
        idle_in();
    endtask

    task automatic chk_q(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_stats();
        n_valid = 0; n_drop_pulse = 0; n_tlast = 0; n_unstable = 0;
        max_fill = 0; max_pkt = 0;
        hs_cyc.delete();
    endtask

    initial begin
        beat_t b;
        int    k;
        int    lens[3];
        n_err = 0; n_checks = 0; cyc = 0;
        stall_prev = 1'b0;
        clear_stats();
        areset = 1'b1;
        s_axis_tdata = '0; s_axis_tuser_mty = '0;
        idle_in();
        m_axis_tready = 1'b0;

        #22;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        tick();
        chk("tready_after_rst", s_axis_tready, 1);

        // Test 1: egress held off during ingress so all three packets are resident
        clear_stats();
        lens = '{4, 1, 7};
        k = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < lens[p]; i++) begin
                drive_beat(mk_beat(p + 1, i, lens[p]), 1'b0);
                exp_q.push_back(mk_beat(p + 1, i, lens[p]));
                tick();
                k++;
                if (k == 5 || k == 6) chk("t1_latency_early", m_axis_tvalid, 0);
                if (k == 7) chk("t1_latency_tvalid", m_axis_tvalid, 1);
            end
        end
        idle_in();
        tick();
        chk("t1_pkt_count_peak", pkt_count, 3);
        repeat (3) tick();
        chk("t1_fill_level", fill_level, 12);
        b = mk_beat(1, 0, 4);
        chk("t1_head_tdata", m_axis_tdata, b[34:3]);
        m_axis_tready = 1'b1;
        repeat (30) tick();
        chk("t1_handshakes", hs_cyc.size(), 12);
        if (hs_cyc.size() == 12)
            chk("t1_back_to_back", hs_cyc[11] - hs_cyc[0], 11);
        chk_q("t1_egress");
        chk("t1_max_pkt", max_pkt, 3);
        chk("t1_pkt_count_end", pkt_count, 0);
        chk("t1_fill_end", fill_level, 0);

        // Test 2: 20-beat packet overflows the 16-beat RAM
        clear_stats();
        send_pkt(10, 20, 0, 1'b0, 1'b0);
        send_pkt(11, 3, 0, 1'b0, 1'b1);
        repeat (20) tick();
        chk_q("t2_egress");
        chk("t2_drop_pulses", n_drop_pulse, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_max_fill_le16", max_fill <= 16, 1);
        chk("t2_fill_end", fill_level, 0);

        // Test 3: abort on beat 3 of a 5-beat packet
        clear_stats();
        send_pkt(20, 5, 3, 1'b0, 1'b0);
        repeat (5) tick();
        chk("t3_no_valid", n_valid, 0);
        chk("t3_fill_after_abort", fill_level, 0);
        send_pkt(21, 2, 0, 1'b0, 1'b1);
        repeat (20) tick();
        chk_q("t3_egress");
        chk("t3_drop_pulses", n_drop_pulse, 1);
        chk("t3_drop_cnt", drop_cnt, 2);

        // Test 4: abort in IDLE without a beat is ignored; abort on tlast discards
        clear_stats();
        drop_incmpt_pkt = 1'b1;
        tick();
        drop_incmpt_pkt = 1'b0;
        repeat (2) tick();
        chk("t4_idle_abort_drop_cnt", drop_cnt, 2);
        send_pkt(30, 4, 4, 1'b0, 1'b0);
        repeat (10) tick();
        chk("t4_max_pkt", max_pkt, 0);
        chk("t4_no_valid", n_valid, 0);
        chk("t4_drop_cnt", drop_cnt, 3);
        chk("t4_drop_pulses", n_drop_pulse, 1);
        chk_q("t4_egress");

        // Test 5: random egress back-pressure while a third packet commits
        clear_stats();
        m_axis_tready = 1'b0;
        send_pkt(40, 5, 0, 1'b0, 1'b1);
        send_pkt(41, 4, 0, 1'b0, 1'b1);
        tick();
        chk("t5_pkt_count_before", pkt_count, 2);
        send_pkt(42, 5, 0, 1'b1, 1'b1);
        chk("t5_pkt_count_mid", pkt_count, 3 - n_tlast);
        repeat (60) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            tick();
        end
        m_axis_tready = 1'b1;
        repeat (30) tick();
        chk_q("t5_egress");
        chk("t5_stall_stable", n_unstable, 0);
        chk("t5_pkt_count_end", pkt_count, 0);
        chk("t5_fill_end", fill_level, 0);

        // Test 6: asynchronous reset mid-egress and mid-ingress
        clear_stats();
        send_pkt(50, 6, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_beat(mk_beat(51, i, 8), 1'b0);
            tick();
        end
        tick();
        chk("t6_mid_egress_valid", m_axis_tvalid, 1);
        #2;
        areset = 1'b1;
        #1;
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tdata", m_axis_tdata, 0);
        chk("t6_rst_tlast", m_axis_tlast, 0);
        chk("t6_rst_mty", m_axis_tuser_mty, 0);
        chk("t6_rst_tready", s_axis_tready, 0);
        chk("t6_rst_pkt_count", pkt_count, 0);
        chk("t6_rst_fill", fill_level, 0);
        idle_in();
        @(posedge aclk); #1;
        areset = 1'b0;
        got_q.delete();
        exp_q.delete();
        tick();
        chk("t6_tready_after", s_axis_tready, 1);
        send_pkt(52, 2, 0, 1'b0, 1'b1);
        repeat (20) tick();
        chk_q("t6_egress");
        chk("t6_drop_cnt", drop_cnt, 0);
        chk("t6_pkt_count_end", pkt_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
